// File: rtl/seq_mult_8bit.sv
// seq_mult_8bit: 8x8 unsigned shift-add multiplier, one iteration per clock.
// Optional SEQ_MULT_ZERO_SKIP_EN: zero operands bypass the iterations.
module seq_mult_8bit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        busy,
    output logic        done,
    output logic [15:0] product
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [7:0]  m_q, m_d;
    logic [7:0]  q_q, q_d;
    logic [7:0]  acc_q, acc_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] product_q, product_d;

    logic        accept;
    logic [7:0]  add_x, add_y;
    logic [7:0]  gen, prop;
    logic [8:0]  carry;
    logic [7:0]  sum;
    logic [7:0]  acc_sh;
    logic [7:0]  q_sh;

    assign accept = start && (state_q != S_RUN);

    // Carry-lookahead add of ACC and the Q[0]-gated multiplicand, cin = 0.
    always_comb begin
        add_x = acc_q;
        add_y = q_q[0] ? m_q : 8'd0;
        gen   = add_x & add_y;
        prop  = add_x ^ add_y;
        carry[0] = 1'b0;
        carry[1] = gen[0];
        carry[2] = gen[1] | (prop[1] & gen[0]);
        carry[3] = gen[2] | (prop[2] & gen[1])
                 | (prop[2] & prop[1] & gen[0]);
        carry[4] = gen[3] | (prop[3] & gen[2])
                 | (prop[3] & prop[2] & gen[1])
                 | (prop[3] & prop[2] & prop[1] & gen[0]);
        carry[5] = gen[4] | (prop[4] & carry[4]);
        carry[6] = gen[5] | (prop[5] & gen[4])
                 | (prop[5] & prop[4] & carry[4]);
        carry[7] = gen[6] | (prop[6] & gen[5])
                 | (prop[6] & prop[5] & gen[4])
                 | (prop[6] & prop[5] & prop[4] & carry[4]);
        carry[8] = gen[7] | (prop[7] & gen[6])
                 | (prop[7] & prop[6] & gen[5])
                 | (prop[7] & prop[6] & prop[5] & gen[4])
                 | (prop[7] & prop[6] & prop[5] & prop[4] & carry[4]);
        sum = prop ^ carry[7:0];
    end

    // Right shift of {C,ACC,Q}: carry-out becomes the new ACC MSB.
    always_comb begin
        acc_sh = {carry[8], sum[7:1]};
        q_sh   = {sum[0], q_q[7:1]};
    end

    // Next-state and datapath control.
    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        q_d       = q_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    m_d   = a;
                    q_d   = b;
                    acc_d = 8'd0;
                    cnt_d = 3'd0;
`ifdef SEQ_MULT_ZERO_SKIP_EN
                    if ((a == 8'd0) || (b == 8'd0)) begin
                        product_d = 16'd0;
                        state_d   = S_DONE;
                    end else begin
                        state_d = S_RUN;
                    end
`else
                    state_d = S_RUN;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                acc_d = acc_sh;
                q_d   = q_sh;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    product_d = {acc_sh, q_sh};
                    state_d   = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            m_q       <= 8'd0;
            q_q       <= 8'd0;
            acc_q     <= 8'd0;
            cnt_q     <= 3'd0;
            product_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            q_q       <= q_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign busy    = (state_q == S_RUN);
    assign done    = (state_q == S_DONE);
    assign product = product_q;

endmodule

// File: tb/tb_seq_mult_8bit.sv
// tb_seq_mult_8bit: directed and swept checks of seq_mult_8bit.
// Define SEQ_MULT_ZERO_SKIP_EN to match a zero-skip build.
module tb_seq_mult_8bit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [15:0] product;

    int total = 0;
    int bad   = 0;

`ifdef SEQ_MULT_ZERO_SKIP_EN
    localparam int ZERO_K    = 1;
    localparam int ZERO_BUSY = 0;
`else
    localparam int ZERO_K    = 9;
    localparam int ZERO_BUSY = 8;
`endif

    always #5 clk = ~clk;

    seq_mult_8bit dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [7:0] x, input logic [7:0] y);
        a     = x;
        b     = y;
        start = 1'b1;
    endtask

    // k = negedge samples until done seen (0 if never); inputs scrambled
    // after acceptance to show the operation in flight ignores them.
    task automatic wait_done(input int lim, output int k, output int bn);
        k  = 0;
        bn = 0;
        for (int i = 1; i <= lim; i++) begin
            @(negedge clk);
            start = 1'b0;
            a     = 8'($urandom);
            b     = 8'($urandom);
            if (busy) bn++;
            if (done) begin
                k = i;
                break;
            end
        end
    endtask

    task automatic count_done(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done) cnt++;
        end
    endtask

    logic [7:0]  cx [7] = '{8'd0, 8'd1, 8'd255, 8'd1, 8'd128, 8'd255, 8'd170};
    logic [7:0]  cy [7] = '{8'd0, 8'd1, 8'd1, 8'd255, 8'd128, 8'd254, 8'd85};

    initial begin
        int k, bn, dn;
        logic [7:0]  rx, ry;
        logic [15:0] want;

        rst   = 1'b1;
        start = 1'b0;
        a     = 8'd0;
        b     = 8'd0;
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_prod", 32'(product), 32'd0);

        // 255*255, start on the first edge after reset release.
        @(negedge clk);
        rst = 1'b0;
        issue(8'd255, 8'd255);
        wait_done(20, k, bn);
        check("ff_k", 32'(k), 32'd9);
        check("ff_busy", 32'(bn), 32'd8);
        check("ff_prod", 32'(product), 32'd65025);
        @(negedge clk);
        check("ff_pulse", 32'(done), 32'd0);
        check("ff_hold", 32'(product), 32'd65025);

        // Back-to-back: second start during DONE.
        issue(8'd13, 8'd11);
        wait_done(20, k, bn);
        check("bb1_k", 32'(k), 32'd9);
        check("bb1_prod", 32'(product), 32'd143);
        issue(8'd200, 8'd3);
        @(negedge clk);
        start = 1'b0;
        check("bb_busy", 32'(busy), 32'd1);
        check("bb_hold", 32'(product), 32'd143);
        wait_done(20, k, bn);
        check("bb2_k", 32'(k), 32'd8);
        check("bb2_prod", 32'(product), 32'd600);

        // Zero operand.
        @(negedge clk);
        issue(8'd0, 8'd200);
        wait_done(20, k, bn);
        check("z_k", 32'(k), 32'(ZERO_K));
        check("z_busy", 32'(bn), 32'(ZERO_BUSY));
        check("z_prod", 32'(product), 32'd0);

        // Start while busy is ignored.
        @(negedge clk);
        @(negedge clk);
        issue(8'd7, 8'd9);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        issue(8'd100, 8'd100);
        wait_done(20, k, bn);
        check("ign_k", 32'(k), 32'd6);
        check("ign_prod", 32'(product), 32'd63);
        count_done(12, dn);
        check("ign_ndone", 32'(dn), 32'd0);
        check("ign_hold", 32'(product), 32'd63);

        // Reset mid-run aborts.
        @(negedge clk);
        issue(8'd128, 8'd2);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("ab_busy", 32'(busy), 32'd0);
        check("ab_done", 32'(done), 32'd0);
        check("ab_prod", 32'(product), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        count_done(12, dn);
        check("ab_ndone", 32'(dn), 32'd0);
        check("ab_prod2", 32'(product), 32'd0);
        issue(8'd128, 8'd2);
        wait_done(20, k, bn);
        check("ab_k", 32'(k), 32'd9);
        check("ab_prod3", 32'(product), 32'd256);

        // Corner pairs then random sweep, issued back-to-back.
        for (int i = 0; i < 7; i++) begin
            rx   = cx[i];
            ry   = cy[i];
            want = 16'(rx) * 16'(ry);
            issue(rx, ry);
            wait_done(20, k, bn);
            check("corner", 32'(product), 32'(want));
        end
        for (int i = 0; i < 2000; i++) begin
            rx   = 8'($urandom);
            ry   = 8'($urandom);
            want = 16'(rx) * 16'(ry);
            issue(rx, ry);
            wait_done(20, k, bn);
            check("rand", 32'(product), 32'(want));
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
